// File: rtl/nios_hps_system_button_ctrl_if.sv
// Avalon-MM register port for the push-button controller.
// The Nios master drives the strobes and the controller returns registered read data.
interface nios_hps_system_button_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_hps_system_button_ctrl.sv
// Push-button controller: synchronise, debounce, sticky press capture and maskable irq.
// Build option BUTTON_CTRL_BOTH_EDGE_EN also captures releases and maps stable_prev onto register 1.
module nios_hps_system_button_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                            clk,
    input  logic                            reset,
    nios_hps_system_button_ctrl_if.slave    avs,
    input  logic [WIDTH-1:0]                in_port,
    output logic                            irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RAW      = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CW-1:0]    cnt [WIDTH];

    logic [WIDTH-1:0] event_set;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] raw_view;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign unused_bits = ^avs.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A bit must disagree with its stable level for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        event_set = '0;
        raw_view  = '0;
        clr_mask  = '0;
        rd_mux    = '0;
`ifdef BUTTON_CTRL_BOTH_EDGE_EN
        event_set = stable_prev ^ stable;
        raw_view  = stable_prev;
`else
        event_set = stable_prev & ~stable;
        raw_view  = sync2;
`endif
        if (avs.write && (avs.address == ADDR_EDGE_CAP)) begin
            clr_mask = avs.writedata[WIDTH-1:0];
        end
        case (avs.address)
            ADDR_DATA:     rd_mux = 32'(stable);
            ADDR_RAW:      rd_mux = 32'(raw_view);
            ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE_CAP: rd_mux = 32'(edge_capture);
            default:       rd_mux = '0;
        endcase
    end

    // Set beats clear on the same bit; irq is built only from registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev  <= '1;
            irq_mask     <= '0;
            edge_capture <= '0;
            avs.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            stable_prev <= stable;
            if (avs.write && (avs.address == ADDR_IRQ_MASK)) begin
                irq_mask <= avs.writedata[WIDTH-1:0];
            end
            edge_capture <= (edge_capture & ~clr_mask) | event_set;
            avs.readdata <= avs.read ? rd_mux : 32'd0;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_nios_hps_system_button_ctrl.sv
// Self-checking bench for nios_hps_system_button_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_nios_hps_system_button_ctrl;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_port = '1;
    logic         irq;

    int n_checks = 0;
    int n_pass   = 0;

    nios_hps_system_button_ctrl_if bus ();

    nios_hps_system_button_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: two-sample pin delay, run length of disagreeing samples per button.
    logic [W-1:0] m_s1 = '1, m_s2 = '1, m_stable = '1, m_prev = '1;
    logic [W-1:0] m_ec = '0, m_mask = '0;
    int           m_run [W];
    logic [31:0]  m_rd = '0;
    logic         m_irq = 1'b0;

    task automatic model_step();
        logic [W-1:0] press, clr, raw;
        logic [31:0]  rd;
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_stable = '1; m_prev = '1;
            m_ec = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
`ifdef BUTTON_CTRL_BOTH_EDGE_EN
            press = m_prev ^ m_stable;
            raw   = m_prev;
`else
            press = m_prev & ~m_stable;
            raw   = m_s2;
`endif
            rd = '0;
            if (bus.read) begin
                case (bus.address)
                    2'd0: rd = {28'd0, m_stable};
                    2'd1: rd = {28'd0, raw};
                    2'd2: rd = {28'd0, m_mask};
                    default: rd = {28'd0, m_ec};
                endcase
            end
            m_irq = |(m_ec & m_mask);
            clr = (bus.write && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
            m_ec = (m_ec & ~clr) | press;
            if (bus.write && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
            m_prev = m_stable;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_stable[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = in_port;
            m_rd = rd;
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.read = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
        bus.address   = a;
        bus.writedata = wd;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_r [4];
        exp_r[0] = 32'hF; exp_r[1] = 32'hF; exp_r[2] = 32'h0; exp_r[3] = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.readdata !== 32'h0 || irq !== 1'b0)
            $display("FAIL reset_outputs: readdata=%h irq=%b want 0/0", bus.readdata, irq);
        else n_pass++;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a), d);
            n_checks++;
            if (d !== exp_r[a] || d !== m_rd)
                $display("FAIL reset_read addr%0d: got %h want %h", a, d, exp_r[a]);
            else n_pass++;
        end
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        int first = 0;
        bus.address = 2'd0;
        bus.read    = 1'b1;
        in_port     = 4'hE;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.readdata !== m_rd)
                $display("FAIL press_data cyc%0d: got %h want %h", k, bus.readdata, m_rd);
            else n_pass++;
            if (first == 0 && bus.readdata[3:0] == 4'hE) first = k;
        end
        bus.read = 1'b0;
        n_checks++;
        if (first != 7) $display("FAIL press_latency: first read of 0xE at %0d want 7", first);
        else n_pass++;
        do_read(2'd3, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL press_capture: got %h want 1", d);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL press_irq_masked: got %b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        in_port = 4'hF;
        repeat (10) @(negedge clk);
        do_write(2'd3, 32'hF);
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) in_port[1] = ~in_port[1];
            @(negedge clk);
            n_checks++;
            if (irq !== m_irq) $display("FAIL bounce_irq cyc%0d: got %b want %b", k, irq, m_irq);
            else n_pass++;
        end
        in_port = 4'hF;
        repeat (8) @(negedge clk);
        do_read(2'd0, d);
        n_checks++;
        if (d !== 32'hF) $display("FAIL bounce_data: got %h want F", d);
        else n_pass++;
        do_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL bounce_capture: got %h want 0", d);
        else n_pass++;
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        do_write(2'd2, 32'h1);
        in_port = 4'hE;
        repeat (9) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1 || m_irq !== 1'b1) $display("FAIL irq_assert: got %b want 1", irq);
        else n_pass++;
        do_write(2'd3, 32'h1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_clear_lag: got %b want 1", irq);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_deassert: got %b want 0", irq);
        else n_pass++;
        do_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL irq_capture_cleared: got %h want 0", d);
        else n_pass++;
        in_port = 4'hF;
        repeat (8) @(negedge clk);
        do_write(2'd3, 32'hF);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        in_port = 4'hB;
        repeat (6) @(negedge clk);
        do_write(2'd3, 32'h4);
        do_read(2'd3, d);
        n_checks++;
        if (d !== 32'h4 || d !== m_rd) $display("FAIL collision_set_wins: got %h want 4", d);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL collision_irq: got %b want 0", irq);
        else n_pass++;
        in_port = 4'hF;
        repeat (8) @(negedge clk);
        do_write(2'd3, 32'hF);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] rd1;
        int first = 0;
        in_port = 4'h7;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.address = 2'd0;
        bus.read    = 1'b1;
        rd1 = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) rd1 = bus.readdata;
            n_checks++;
            if (bus.readdata !== m_rd)
                $display("FAIL rstmid_data cyc%0d: got %h want %h", k, bus.readdata, m_rd);
            else n_pass++;
            if (first == 0 && bus.readdata[3:0] == 4'h7) first = k;
        end
        bus.read = 1'b0;
        n_checks++;
        if (rd1 !== 32'hF) $display("FAIL rstmid_released: got %h want F", rd1);
        else n_pass++;
        n_checks++;
        if (first != 7) $display("FAIL rstmid_latency: first read of 0x7 at %0d want 7", first);
        else n_pass++;
        do_read(2'd3, d);
        n_checks++;
        if (d !== 32'h8) $display("FAIL rstmid_capture: got %h want 8", d);
        else n_pass++;
        in_port = 4'hF;
        repeat (8) @(negedge clk);
        do_write(2'd3, 32'hF);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.readdata !== m_rd || irq !== m_irq)
                $display("FAIL random cyc%0d: readdata=%h irq=%b want %h/%b",
                         c, bus.readdata, irq, m_rd, m_irq);
            else n_pass++;
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ 4'(1 << $urandom_range(0, 3));
            bus.read      = 1'($urandom_range(0, 1));
            bus.write     = ($urandom_range(0, 3) == 0);
            bus.address   = 2'($urandom_range(0, 3));
            bus.writedata = $urandom;
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.readdata !== m_rd || irq !== m_irq)
            $display("FAIL random_final: readdata=%h irq=%b want %h/%b", bus.readdata, irq, m_rd, m_irq);
        else n_pass++;
    endtask

    initial begin
        bus.address   = 2'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_interrupt();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
